mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR memory interface. It answers the Read/Write strobes raised by the control sequencer.
- It holds a word-addressed RAM. It decodes the address presented on MARVal. Reads return data toward MDRin; writes commit the MDR contents.
- It signals completion with a level mem_done using a four-phase handshake, so the control unit can stretch its memory T-states over programmable wait states.

Parameters:
- BITS, 32, data word width (matches datapath BITS).
- ADDR_BITS, 9, number of MARVal low bits used as the word address.
- DEPTH, 512, number of words implemented; must be <= 2**ADDR_BITS.
- WAIT_STATES, 1, extra cycles inserted before the access cycle; range 0..15.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous active-low reset.
- Read, input, 1, read request level from control unit.
- Write, input, 1, write request level from control unit.
- MARVal, input, BITS, address from MAR; only bits [ADDR_BITS-1:0] are decoded.
- MDRVal, input, BITS, write data from MDR.
- Mdatain, output, BITS, read data toward MDR input mux.
- mem_done, output, 1, access complete; held until the request drops.
- mem_busy, output, 1, high in WAIT and ACCESS.
- mem_err, output, 1, sticky error flag.

Behaviour:
- Reset: when reset=0 at a clock edge, FSM goes to IDLE. Mdatain=0, mem_done=0, mem_busy=0, mem_err=0, wait counter=0. RAM contents are not cleared.
- Reset during WAIT or ACCESS aborts the operation. No RAM write occurs on that edge.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Request = Read XOR Write, sampled at an edge (e0).
  - On a request: latch the address (MARVal[ADDR_BITS-1:0] mod DEPTH), the write data, and the direction. Load the counter with WAIT_STATES. Go to WAIT, or to ACCESS if WAIT_STATES=0.
  - If Read and Write are both 1: set mem_err=1, stay in IDLE, perform no access.
- WAIT: at each edge, if the counter is 1, go to ACCESS; otherwise decrement. WAIT lasts exactly WAIT_STATES cycles.
- ACCESS: at its closing edge:
  - Write: RAM[addr] <= latched data.
  - Read: Mdatain <= RAM[addr].
  - Go to DONE.
- DONE:
  - mem_done=1.
  - Return to IDLE at the first edge where Read=0 and Write=0. mem_done falls at that same edge.
  - New requests are ignored until IDLE is re-entered.
- Latency: mem_done rises at edge e0+WAIT_STATES+1. With the default parameter it is high in the second cycle after e0.
- Abort: if the latched request bit drops while in WAIT, go to IDLE at the next edge. No RAM write, and Mdatain is unchanged.
- Latching: address and data are latched at e0. Changes to MARVal or MDRVal after e0 do not affect the access.
- Mdatain holds the last completed read value until the next read completes. Writes never alter Mdatain.
- mem_err is sticky: it is cleared only by reset.

Optional Feature:
- Macro name: MEM_BOUNDS_CHECK_EN.
- Defined:
  - An address with MARVal[ADDR_BITS-1:0] >= DEPTH is not wrapped.
  - The FSM still walks WAIT, ACCESS and DONE with normal timing.
  - No RAM write occurs; a read returns 0 on Mdatain.
  - mem_err is set at the ACCESS edge.
- Undefined: out-of-range addresses wrap modulo DEPTH, and mem_err is set only by a simultaneous Read/Write.

Test Plan:
- Write then read back: reset, WAIT_STATES=1. Write=1, MARVal=0x012, MDRVal=0x0000_00A5 → mem_done rises 2 edges after e0; drop Write → mem_done falls. Read=1, MARVal=0x012 → Mdatain=0x0000_00A5 when mem_done rises.
- Zero wait states: WAIT_STATES=0, read of an address preloaded with 0x1234_5678 → mem_done high 1 edge after e0, mem_busy high for exactly 1 cycle.
- Four-phase hold: keep Read=1 for 5 cycles after mem_done rises → mem_done stays 1, RAM not re-read (change RAM via a second port-free write attempt: ignored). Drop Read → IDLE next edge.
- Abort: WAIT_STATES=3, Write=1 to 0x020 with data 0xDEAD_BEEF, drop Write during the 2nd WAIT cycle → mem_done never rises. A later read of 0x020 returns the prior value (0).
- Conflict and reset: Read=Write=1 → mem_err=1, no access. Then start a write and assert reset=0 during ACCESS → all outputs 0 next edge, target word unchanged.
- Bounds: DEPTH=256, read MARVal=0x105 → without MEM_BOUNDS_CHECK_EN returns RAM[0x05], mem_err stays 0. With the macro: Mdatain=0 and mem_err=1.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM that answers the sequencer's Read/Write
// strobes through a four-phase handshake. mem_done is a level signal.
// Ports: clk; reset (synchronous, active low); Read and Write (request
//   levels); MARVal (address); MDRVal (write data); Mdatain (read data);
//   mem_done (held until the request drops); mem_busy (WAIT/ACCESS);
//   mem_err (sticky error flag).
// Optional: define MEM_BOUNDS_CHECK_EN to reject addresses >= DEPTH
//   instead of wrapping them.
module mem_responder #(
    parameter int BITS        = 32,
    parameter int ADDR_BITS   = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Read,
    input  logic            Write,
    input  logic [BITS-1:0] MARVal,
    input  logic [BITS-1:0] MDRVal,
    output logic [BITS-1:0] Mdatain,
    output logic            mem_done,
    output logic            mem_busy,
    output logic            mem_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [BITS-1:0]      data_q;
    logic                 wr_q;

    logic [BITS-1:0] mem [DEPTH];

    logic [ADDR_BITS:0] addr_ext;
    logic [ADDR_BITS:0] addr_wrap;
    logic [IW-1:0]      idx;
    logic               oob;
    logic               req;
    logic               conflict;
    logic               req_held;

    assign req      = Read ^ Write;
    assign conflict = Read & Write;
    // The strobe that started the access must stay up for it to continue.
    assign req_held = wr_q ? Write : Read;

    // One spare bit so that DEPTH == 2**ADDR_BITS is representable.
    assign addr_ext  = {1'b0, addr_q};
    assign addr_wrap = addr_ext % (ADDR_BITS+1)'(DEPTH);
    assign idx       = addr_wrap[IW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = (addr_ext >= (ADDR_BITS+1)'(DEPTH));
`else
    assign oob = 1'b0;
`endif

    logic unused_wrap;
    assign unused_wrap = ^addr_wrap[ADDR_BITS:IW];

    if (BITS > ADDR_BITS) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^MARVal[BITS-1:ADDR_BITS];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    state_n = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_held) begin
                    state_n = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: state_n = S_DONE;
            S_DONE: begin
                if (!Read && !Write) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Mdatain <= '0;
            mem_err <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE: begin
                    if (conflict) begin
                        mem_err <= 1'b1;
                    end else if (req) begin
                        addr_q <= MARVal[ADDR_BITS-1:0];
                        data_q <= MDRVal;
                        wr_q   <= Write;
                        cnt    <= 4'(WAIT_STATES);
                    end
                end
                S_WAIT: begin
                    if (req_held && cnt != 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (oob) begin
                        mem_err <= 1'b1;
                    end
                    if (!wr_q) begin
                        Mdatain <= oob ? '0 : mem[idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // A reset asserted on the ACCESS closing edge suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && state == S_ACCESS && wr_q && !oob) begin
            mem[idx] <= data_q;
        end
    end

    assign mem_done = (state == S_DONE);
    assign mem_busy = (state == S_WAIT) || (state == S_ACCESS);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder.
// Stimulus pushes expected responses; a negedge monitor pops on mem_done.
module tb_mem_responder;

    localparam int BITS  = 32;
    localparam int AB    = 9;
    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            Read   = 1'b0;
    logic            Write  = 1'b0;
    logic [BITS-1:0] MARVal = '0;
    logic [BITS-1:0] MDRVal = '0;
    logic [BITS-1:0] Mdatain;
    logic            mem_done;
    logic            mem_busy;
    logic            mem_err;

    mem_responder #(
        .BITS(BITS),
        .ADDR_BITS(AB),
        .DEPTH(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Read(Read),
        .Write(Write),
        .MARVal(MARVal),
        .MDRVal(MDRVal),
        .Mdatain(Mdatain),
        .mem_done(mem_done),
        .mem_busy(mem_busy),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mdat;
        logic        err;
        int          e0;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_mdat;
    logic        ref_err;
    int          edges   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        done_prev = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act,
                          input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Monitor: every rising mem_done consumes one expected response.
    always @(negedge clk) begin
        if (mem_done && !done_prev) begin
            if (sbq.size() == 0) begin
                check1("unexpected_done", mem_done, 1'b0);
            end else begin
                mon_e = sbq.pop_front();
                check("latency", edges - mon_e.e0, WS + 1);
                check("mdatain", Mdatain, mon_e.mdat);
                check1("err", mem_err, mon_e.err);
            end
        end
        done_prev = mem_done;
    end

    // Called at a negedge with the DUT idle; returns idle at a negedge.
    task automatic access(input bit wr, input logic [31:0] mar,
                          input logic [31:0] wd, input int hold);
        int idx;
        bit oob;
        int busy_n;
        bit got;
        idx = int'(mar[AB-1:0]);
        oob = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        oob = (idx >= DEPTH);
`endif
        idx = idx % DEPTH;
        if (oob) ref_err = 1'b1;
        if (wr) begin
            if (!oob) ref_mem[idx] = wd;
        end else begin
            ref_mdat = oob ? 32'd0 : ref_mem[idx];
        end
        sbq.push_back('{ref_mdat, ref_err, edges + 1});
        Read   = !wr;
        Write  = wr;
        MARVal = mar;
        MDRVal = wd;
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                MARVal = $urandom;
                MDRVal = $urandom;
            end
            if (mem_busy) busy_n++;
            got = mem_done;
        end
        check1("done_timeout", got, 1'b1);
        check("busy_cycles", busy_n, WS + 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check1("done_hold", mem_done, 1'b1);
            check("hold_mdat", Mdatain, ref_mdat);
        end
        Read  = 1'b0;
        Write = 1'b0;
        @(negedge clk);
        check1("done_fall", mem_done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        ref_mdat = '0;
        ref_err  = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mdat", Mdatain, 32'd0);
        check1("rst_done", mem_done, 1'b0);
        check1("rst_busy", mem_busy, 1'b0);
        check1("rst_err", mem_err, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        for (int a = 0; a < DEPTH; a++) begin
            access(1'b1, (32'($urandom) << AB) | 32'(a), $urandom, 0);
        end

        access(1'b1, 32'h012, 32'h0000_00A5, 0);
        access(1'b0, 32'h012, 32'h0, 5);
        access(1'b0, 32'h105, 32'h0, 1);

        for (int n = 0; n < 200; n++) begin
            access(bit'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom_range(0, 3));
        end

        // Abort in the last WAIT cycle: the write must not land.
        Write  = 1'b1;
        MARVal = 32'h020;
        MDRVal = 32'hDEAD_BEEF;
        @(negedge clk);
        check1("abort_busy", mem_busy, 1'b1);
        @(negedge clk);
        Write = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check1("abort_no_done", mem_done, 1'b0);
            check1("abort_idle", mem_busy, 1'b0);
        end
        access(1'b0, 32'h020, 32'h0, 0);

        check1("err_before", mem_err, ref_err);
        Read  = 1'b1;
        Write = 1'b1;
        @(negedge clk);
        check1("conflict_err", mem_err, 1'b1);
        check1("conflict_busy", mem_busy, 1'b0);
        Read    = 1'b0;
        Write   = 1'b0;
        ref_err = 1'b1;
        @(negedge clk);
        access(1'b0, 32'h033, 32'h0, 0);

        // Reset while in ACCESS: outputs clear, the target word survives.
        v      = ~ref_mem[8'h44];
        Write  = 1'b1;
        MARVal = 32'h044;
        MDRVal = v;
        repeat (WS + 1) @(negedge clk);
        check1("rst_acc_busy", mem_busy, 1'b1);
        reset = 1'b0;
        Write = 1'b0;
        @(negedge clk);
        check("rst2_mdat", Mdatain, 32'd0);
        check1("rst2_done", mem_done, 1'b0);
        check1("rst2_busy", mem_busy, 1'b0);
        check1("rst2_err", mem_err, 1'b0);
        reset    = 1'b1;
        ref_mdat = '0;
        ref_err  = 1'b0;
        @(negedge clk);
        access(1'b0, 32'h044, 32'h0, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
